// File: rtl/switch_debounce_pkg.sv
// Shared constants for the slide-switch conditioning path.
package switch_debounce_pkg;
  localparam int SW_WIDTH           = 8;
  localparam int DEBOUNCE_1MS_50MHZ = 50000;
endpackage

// File: rtl/switch_debounce_bit.sv
// Single switch bit: two-flop synchroniser, stability counter and accepted-level flop.
module debounce_bit #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic changed,
  output logic accept
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  // accept is the combinational "level flips on this edge" term, so the top
  // can register the OR of all bits in the same cycle that changed rises.
  assign accept = (sync2 != level) && (cnt == TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      changed <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level   <= sync2;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/switch_debounce.sv
// WIDTH-wide switch debouncer feeding the PIO in_port, with per-bit and
// aggregate change pulses for a later edge-capture/IRQ stage.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  logic [WIDTH-1:0] accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[gi]),
      .level  (sw_out[gi]),
      .changed(sw_changed[gi]),
      .accept (accept[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_change <= 1'b0;
    else          any_change <= |accept;
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboarded bench: run-length reference model predicts every post-edge output.
module tb_switch_debounce;
  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] chg;
    logic         any;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out, sw_changed;
  logic         any_change;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  switch_debounce #(.WIDTH(W), .CNT_W(3), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_out(sw_out), .sw_changed(sw_changed), .any_change(any_change)
  );

  always #5 clk = ~clk;

  // Reference: raw seen through a 2-sample delay line; a level is accepted once
  // the delayed input has disagreed with it for D consecutive edges.
  logic [W-1:0] m_hist[2];
  logic [W-1:0] m_level;
  int           m_run[W];

  always @(posedge clk) begin
    exp_t e;
    logic [W-1:0] seen;
    e.chg = '0;
    if (!reset_n) begin
      m_hist[0] = '0; m_hist[1] = '0; m_level = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      seen = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = sw_raw;
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_level[i] = seen[i];
            e.chg[i]   = 1'b1;
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    e.out = m_level;
    e.any = |e.chg;
    sb.push_back(e);
  end

  // Monitor: pops one expectation per edge and compares just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb.pop_front();
      if (sw_out !== e.out || sw_changed !== e.chg || any_change !== e.any) begin
        failures++;
        $display("FAIL outputs t=%0t got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                 $time, sw_out, sw_changed, any_change, e.out, e.chg, e.any);
      end
    end
  end

  task automatic step(input logic [W-1:0] v, input int n);
    sw_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] want);
    checks++;
    if (sw_out !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, sw_out, want);
    end
  endtask

  initial begin
    m_hist[0] = '0; m_hist[1] = '0; m_level = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;

    // 1 reset with all pins high
    sw_raw = 8'hFF; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset_hold", 8'h00);
    sw_raw = 8'h00; reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 2 clean edge, 3 glitch on bit3
    step(8'h01, 10);
    expect_out("clean_edge", 8'h01);
    step(8'h09, 3);
    step(8'h01, 10);
    expect_out("glitch", 8'h01);

    // 4 simultaneous bits, then bounce on bit0 while bit7 falls
    step(8'h00, 10);
    step(8'hA5, 10);
    expect_out("simul", 8'hA5);
    step(8'h24, 1);
    step(8'h25, 10);
    expect_out("indep", 8'h25);

    // 5 reset mid-count
    step(8'h00, 10);
    step(8'h10, 3);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("mid_reset", 8'h00);
    reset_n = 1'b1;
    step(8'h10, 5);
    expect_out("post_reset_early", 8'h00);
    step(8'h10, 5);
    expect_out("post_reset_full", 8'h10);

    // 6 release all
    step(8'hFF, 10);
    step(8'h00, 10);
    expect_out("release", 8'h00);

    // randomized: mostly-stable levels with short bursts and occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] v;
      v = sw_raw;
      if ($urandom_range(0, 3) == 0) v = v ^ W'($urandom_range(0, 255));
      if ($urandom_range(0, 400) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      step(v, $urandom_range(1, 6));
    end
    reset_n = 1'b1;
    step(sw_raw, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
